key_buzzer_arbiter: RTL and testbench
=====================================

KEY_BUZZER_ARBITER -- requirements
Module: key_buzzer_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000, number of consecutive stable synchronized samples before a key level is accepted; legal range ≥1.
REQ-002 Parameter TONE_CYCLES, default 5000000, exact length in clocks of one granted tone; legal range ≥1.
REQ-003 Parameter GAP_CYCLES, default 1000000, exact length in clocks of silence after each tone; legal range ≥1.
REQ-004 Parameter BASE_HALF, default 25000, half-period unit for tone frequency; key i uses half-period HALF(i) = BASE_HALF*(i+1); legal range ≥1.
REQ-005 clk  input  1  single system clock; all state is on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 key_sw  input  4  raw board keys, active-low (0 = pressed), asynchronous to clk.
REQ-008 led  output  4  active-low owner indicator; led[i]=0 only while key i owns the buzzer.
REQ-009 buzzer  output  1  square-wave drive to the board buzzer.

Function
REQ-010 Each key_sw bit SHALL be inverted and passed through a 2-flop synchronizer before any other use.
REQ-011 Each key SHALL have an independent debouncer: the debounced level changes only after DEBOUNCE_CYCLES consecutive cycles where the synchronized level differs from the current debounced level; any mismatch-free cycle resets that key's counter.
REQ-012 A press event for key i SHALL be a single-cycle pulse on a debounced 0->1 transition; releases generate no event.
REQ-013 A press event SHALL set pending[i]; pending[i] stays set until key i is granted; repeat presses while pending are absorbed (no queue depth beyond 1).
REQ-014 The FSM SHALL have states IDLE, PLAY, GAP.
REQ-015 IDLE: if any pending bit is set, grant the lowest-index pending key (fixed priority, key 0 highest), clear its pending bit, latch owner, go to PLAY on the next edge; otherwise remain IDLE.
REQ-016 PLAY SHALL last exactly TONE_CYCLES clocks, then go to GAP.
REQ-017 GAP SHALL last exactly GAP_CYCLES clocks with buzzer=0 and led=4'b1111, then go to IDLE.
REQ-018 In PLAY, buzzer SHALL be 1 on the first PLAY cycle and toggle every HALF(owner) cycles thereafter.
REQ-019 In IDLE and GAP, buzzer SHALL be 0; led SHALL be 4'b1111.
REQ-020 In PLAY, led SHALL be all-ones except led[owner]=0.
REQ-021 A press event arriving for the current owner during PLAY or GAP SHALL set its pending bit and cause a replay after GAP, subject to priority.
REQ-022 A press event and a grant of the same key in the same cycle: grant clears pending and the event is lost (no double play).
REQ-023 Simultaneous press events on several keys SHALL all set pending; they are played one after another in index order, each separated by GAP.
REQ-024 Counter widths SHALL be sized with $clog2 of their maximum parameter value; no counter may wrap within its legal range.
REQ-025 Outputs SHALL be driven directly from flops (no combinational path from key_sw to led or buzzer).

Reset
REQ-026 While reset=1: state=IDLE, pending=0, all debouncers at released level with counters 0, synchronizers 0, buzzer=0, led=4'b1111, independent of clk.
REQ-027 Reset asserted mid-PLAY or mid-GAP SHALL abort immediately; all pending requests are discarded.
REQ-028 A key held pressed through reset release SHALL generate one press event after debounce (debounced level starts released).

Verification (DEBOUNCE_CYCLES=4, TONE_CYCLES=40, GAP_CYCLES=8, BASE_HALF=2)
REQ-029 key_sw[0] low held -> PLAY entered within 7 cycles; led=4'b1110 for exactly 40 cycles; buzzer high 2 cycles, low 2 cycles, repeating; then 8 cycles buzzer=0, led=4'b1111.
REQ-030 key_sw[1] glitch low for 3 cycles -> no pending, buzzer stays 0, led stays 4'b1111.
REQ-031 key_sw[3] and key_sw[2] pressed the same cycle -> key 2 plays (led=4'b1011, half-period 6), 8-cycle gap, then key 3 (led=4'b0111, half-period 8).
REQ-032 key 3 playing, key 0 pressed mid-tone -> key 3 tone completes full 40 cycles, then gap, then key 0 plays.
REQ-033 Reset asserted at cycle 20 of PLAY with key 1 pending -> buzzer=0, led=4'b1111 asynchronously; after release, no tone plays until a new press.
REQ-034 Owner key released and re-pressed during its own PLAY -> same key replays once after the 8-cycle gap.

Source files
------------

// File: rtl/key_buzzer_arbiter.sv
// Four-key buzzer arbiter: synchronizes and debounces the board keys, queues
// one press per key, and grants the buzzer to the lowest-index pending key.
// The granted key's tone is a fixed-length square wave followed by a fixed
// silent gap.
//
// state | meaning
// IDLE  | buzzer silent, waiting for a pending key
// PLAY  | owner's tone is sounding, led[owner] low
// GAP   | enforced silence after every tone
module key_buzzer_arbiter #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int TONE_CYCLES     = 5000000,
    parameter int GAP_CYCLES      = 1000000,
    parameter int BASE_HALF       = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_sw,
    output logic [3:0] led,
    output logic       buzzer
);

    localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int HW      = $clog2(BASE_HALF * 4 + 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    deb_q, deb_d;
    logic [DW-1:0] cnt_q [4];
    logic [DW-1:0] cnt_d [4];
    logic [3:0]    press;
    logic [3:0]    pend_q, pend_d;
    logic [3:0]    grant_mask;
    logic [1:0]    grant_idx;
    logic          grant_valid;
    state_t        state_q;
    logic [1:0]    owner_q;
    logic [TW-1:0] tmr_q;
    logic [HW-1:0] half_q;
    logic [3:0]    led_q;
    logic          buzz_q;

    // Half-period reload value (minus one) for key k.
    function automatic logic [HW-1:0] half_m1(input logic [1:0] k);
        return HW'(BASE_HALF * (int'(k) + 1) - 1);
    endfunction

    // Two-flop synchronizer on the inverted (active-high) key levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ~key_sw;
            sync2_q <= sync1_q;
        end
    end

    // Per-key debounce: flip the accepted level after DEBOUNCE_CYCLES straight mismatches.
    always_comb begin
        deb_d = deb_q;
        press = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DW'(1);
                end
            end
            press[i] = deb_d[i] & ~deb_q[i];
        end
    end

    // Fixed priority pick of the pending key; the grant wins over a same-cycle press.
    always_comb begin
        grant_valid = |pend_q;
        grant_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) grant_idx = 2'(i);
        end
        grant_mask = (state_q == IDLE && grant_valid) ? (4'b0001 << grant_idx) : 4'b0000;
        pend_d     = (pend_q | press) & ~grant_mask;
    end

    // Debouncer and pending-request state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q  <= '0;
            pend_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            deb_q  <= deb_d;
            pend_q <= pend_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Arbitration FSM with registered led/buzzer drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            tmr_q   <= '0;
            half_q  <= '0;
            led_q   <= 4'b1111;
            buzz_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        state_q <= PLAY;
                        owner_q <= grant_idx;
                        tmr_q   <= TW'(TONE_CYCLES - 1);
                        half_q  <= half_m1(grant_idx);
                        led_q   <= ~(4'b0001 << grant_idx);
                        buzz_q  <= 1'b1;
                    end
                end
                PLAY: begin
                    if (tmr_q == '0) begin
                        state_q <= GAP;
                        tmr_q   <= TW'(GAP_CYCLES - 1);
                        led_q   <= 4'b1111;
                        buzz_q  <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                        if (half_q == '0) begin
                            half_q <= half_m1(owner_q);
                            buzz_q <= ~buzz_q;
                        end else begin
                            half_q <= half_q - HW'(1);
                        end
                    end
                end
                GAP: begin
                    if (tmr_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    led_q   <= 4'b1111;
                    buzz_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led    = led_q;
    assign buzzer = buzz_q;

endmodule

// File: tb/tb_key_buzzer_arbiter.sv
// Directed bench for key_buzzer_arbiter with small timing parameters.
module tb_key_buzzer_arbiter;

    localparam int DEB  = 4;
    localparam int TONE = 40;
    localparam int GAPC = 8;
    localparam int BH   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_sw;
    logic [3:0] led;
    logic       buzzer;

    int n_chk  = 0;
    int n_fail = 0;

    key_buzzer_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .TONE_CYCLES    (TONE),
        .GAP_CYCLES     (GAPC),
        .BASE_HALF      (BH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .key_sw(key_sw),
        .led   (led),
        .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Wait (bounded) until led shows the expected owner pattern.
    task automatic wait_led(input logic [3:0] exp, output int lat);
        lat = 0;
        while (led !== exp && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        chk("tone_start", {28'd0, led}, {28'd0, exp});
    endtask

    // One full tone for key plus its gap; up to two key_sw changes mid-tone.
    task automatic expect_tone(input int key, input int a1_k, input logic [3:0] a1_sw,
                               input int a2_k, input logic [3:0] a2_sw, output int lat);
        logic [3:0] exp_led;
        int half;
        exp_led = 4'b1111 & ~(4'b0001 << key);
        half    = BH * (key + 1);
        wait_led(exp_led, lat);
        for (int k = 0; k < TONE; k++) begin
            if (k == a1_k) key_sw = a1_sw;
            if (k == a2_k) key_sw = a2_sw;
            chk("tone_led", {28'd0, led}, {28'd0, exp_led});
            chk("tone_buzzer", {31'd0, buzzer}, {31'd0, ((k / half) % 2) == 0});
            @(negedge clk);
        end
        for (int g = 0; g < GAPC; g++) begin
            chk("gap_led", {28'd0, led}, 32'hF);
            chk("gap_buzzer", {31'd0, buzzer}, 32'd0);
            @(negedge clk);
        end
    endtask

    // Count cycles with any activity; silence expected throughout.
    task automatic expect_quiet(input string tag, input int n);
        int bad;
        bad = 0;
        for (int c = 0; c < n; c++) begin
            if (led !== 4'hF || buzzer !== 1'b0) bad++;
            @(negedge clk);
        end
        chk(tag, bad, 0);
    endtask

    task automatic release_all();
        key_sw = 4'hF;
        repeat (15) @(negedge clk);
    endtask

    int lat;

    initial begin
        reset  = 1'b1;
        key_sw = 4'hF;
        repeat (3) @(negedge clk);
        chk("reset_led", {28'd0, led}, 32'hF);
        chk("reset_buzzer", {31'd0, buzzer}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Key 0 held: 2 sync + 4 debounce + 1 grant edge = 7 cycles to PLAY.
        key_sw = 4'b1110;
        expect_tone(0, -1, 4'hF, -1, 4'hF, lat);
        chk("play_latency", lat, 7);
        key_sw = 4'hF;
        expect_quiet("no_replay_key0", 30);

        // Three-cycle glitch on key 1 is filtered.
        key_sw = 4'b1101;
        repeat (3) @(negedge clk);
        key_sw = 4'hF;
        expect_quiet("glitch_quiet", 30);

        // Keys 3 and 2 together: 2 first, then 3.
        key_sw = 4'b0011;
        expect_tone(2, -1, 4'hF, -1, 4'hF, lat);
        expect_tone(3, -1, 4'hF, -1, 4'hF, lat);
        chk("second_after_idle", lat, 1);
        release_all();
        expect_quiet("after_pair_quiet", 20);

        // Key 3 playing, key 0 pressed mid-tone: key 3 finishes, then key 0.
        key_sw = 4'b0111;
        expect_tone(3, 10, 4'b0110, -1, 4'hF, lat);
        expect_tone(0, -1, 4'hF, -1, 4'hF, lat);
        release_all();
        expect_quiet("after_preempt_quiet", 20);

        // Owner released and re-pressed during its tone: exactly one replay.
        key_sw = 4'b1101;
        expect_tone(1, 5, 4'hF, 15, 4'b1101, lat);
        expect_tone(1, -1, 4'hF, -1, 4'hF, lat);
        chk("replay_after_gap", lat, 1);
        key_sw = 4'hF;
        expect_quiet("single_replay", 40);

        // Reset at cycle 20 of key 0's tone with key 1 pending.
        key_sw = 4'b1110;
        wait_led(4'b1110, lat);
        for (int k = 0; k < 20; k++) begin
            if (k == 2) key_sw = 4'b1100;
            if (k == 12) key_sw = 4'hF;
            @(negedge clk);
        end
        chk("pre_reset_led", {28'd0, led}, 32'hE);
        chk("pre_reset_buzzer", {31'd0, buzzer}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_led", {28'd0, led}, 32'hF);
        chk("async_reset_buzzer", {31'd0, buzzer}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_quiet("pending_discarded", 60);

        // Key held through reset release yields exactly one play.
        reset  = 1'b1;
        key_sw = 4'b1011;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_tone(2, -1, 4'hF, -1, 4'hF, lat);
        chk("held_through_reset_latency", lat, 7);
        expect_quiet("held_no_repeat", 30);
        key_sw = 4'hF;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
